unidade_controle_exp7: RTL and testbench

UNIDADE_CONTROLE_EXP7 -- requirements
Module: unidade_controle_exp7

---
 rtl/unidade_controle_exp7.sv | 171 +++++++++++++++++
 tb/tb_unidade_controle_exp7.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_exp7.sv
// Control unit for the memory-sequence game (experiment 7).
// Drives the datapath counters, the play register and the memory write
// strobe from a single state register. db_estado always mirrors that
// register so checkers can follow the FSM directly.
// The control strobes are single-cycle level outputs with no handshake:
// the datapath acts on every rising edge on which a strobe is high, and
// the status flags are sampled on the same edge.
module unidade_controle_exp7 (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       enderecoIgualRodada,
    input  logic       fimRod,
    input  logic       fimP,
    input  logic       fimT,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraRod,
    output logic       contaRod,
    output logic       zeraT,
    output logic       contaT,
    output logic       zeraP,
    output logic       contaP,
    output logic       zeraR,
    output logic       registraR,
    output logic       we,
    output logic       sinal_led,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        st_inicial         = 4'h0,
        st_preparacao      = 4'h1,
        st_mostra_primeira = 4'h2,
        st_espera_jogada   = 4'h3,
        st_registra        = 4'h4,
        st_comparacao      = 4'h5,
        st_proximo         = 4'h6,
        st_avanca_end      = 4'h7,
        st_espera_nova     = 4'h8,
        st_registra_nova   = 4'h9,
        st_escreve         = 4'hA,
        st_proxima_rodada  = 4'hB,
        st_acertou         = 4'hC,
        st_errou           = 4'hD,
        st_timeout         = 4'hE
    } state_t;

    state_t state;
    state_t next_state;

    // State register; reset wins over every transition and over iniciar.
    always_ff @(posedge clock) begin
        if (reset) state <= st_inicial;
        else       state <= next_state;
    end

    // Next-state selection.
    always_comb begin
        next_state = st_inicial;
        case (state)
            st_inicial:         next_state = iniciar ? st_preparacao : st_inicial;
            st_preparacao:      next_state = st_mostra_primeira;
            st_mostra_primeira: next_state = fimP ? st_espera_jogada : st_mostra_primeira;
            st_espera_jogada: begin
                // A play arriving together with the timeout still counts.
                if (jogada_feita)  next_state = st_registra;
                else if (fimT)     next_state = st_timeout;
                else               next_state = st_espera_jogada;
            end
            st_registra:        next_state = st_comparacao;
            st_comparacao: begin
                if (!igual)                    next_state = st_errou;
                else if (!enderecoIgualRodada) next_state = st_proximo;
                else if (fimRod)               next_state = st_acertou;
                else                           next_state = st_avanca_end;
            end
            st_proximo:         next_state = st_espera_jogada;
            // Address now points one past the round: that is where the new play is written.
            st_avanca_end:      next_state = st_espera_nova;
            st_espera_nova: begin
                if (jogada_feita)  next_state = st_registra_nova;
                else if (fimT)     next_state = st_timeout;
                else               next_state = st_espera_nova;
            end
            st_registra_nova:   next_state = st_escreve;
            st_escreve:         next_state = st_proxima_rodada;
            st_proxima_rodada:  next_state = st_espera_jogada;
            st_acertou:         next_state = iniciar ? st_preparacao : st_acertou;
            st_errou:           next_state = iniciar ? st_preparacao : st_errou;
            st_timeout:         next_state = iniciar ? st_preparacao : st_timeout;
            default:            next_state = st_inicial;
        endcase
    end

    // Output decode; everything is a function of the state except the
    // timer clear on the exit edge of mostra_primeira.
    always_comb begin
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraRod   = 1'b0;
        contaRod  = 1'b0;
        zeraT     = 1'b0;
        contaT    = 1'b0;
        zeraP     = 1'b0;
        contaP    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        we        = 1'b0;
        sinal_led = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (state)
            st_preparacao: begin
                zeraE   = 1'b1;
                zeraRod = 1'b1;
                zeraR   = 1'b1;
                zeraT   = 1'b1;
                zeraP   = 1'b1;
            end
            st_mostra_primeira: begin
                sinal_led = 1'b1;
                contaP    = 1'b1;
                // Timer starts clean when the first play window opens.
                zeraT     = fimP;
            end
            st_espera_jogada:  contaT = 1'b1;
            st_registra: begin
                registraR = 1'b1;
                zeraT     = 1'b1;
            end
            st_proximo:        contaE = 1'b1;
            st_avanca_end: begin
                contaE = 1'b1;
                zeraT  = 1'b1;
            end
            st_espera_nova:    contaT = 1'b1;
            st_registra_nova:  registraR = 1'b1;
            st_escreve:        we = 1'b1;
            st_proxima_rodada: begin
                contaRod = 1'b1;
                zeraE    = 1'b1;
                zeraT    = 1'b1;
            end
            st_acertou: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            st_errou: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            st_timeout: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = state;

endmodule

// File: tb/tb_unidade_controle_exp7.sv
// Directed bench for unidade_controle_exp7. Outputs are gathered into one
// 16-bit vector (zeraE at bit 15 down to timeout at bit 0) and compared
// together with db_estado against hand-decoded constants.
module tb_unidade_controle_exp7;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       jogada_feita;
    logic       igual;
    logic       enderecoIgualRodada;
    logic       fimRod;
    logic       fimP;
    logic       fimT;
    logic       zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraP, contaP;
    logic       zeraR, registraR, we, sinal_led, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;
    logic [15:0] outs;

    int n_checks = 0;
    int n_errors = 0;

    unidade_controle_exp7 dut (
        .clock(clock), .reset(reset), .iniciar(iniciar),
        .jogada_feita(jogada_feita), .igual(igual),
        .enderecoIgualRodada(enderecoIgualRodada), .fimRod(fimRod),
        .fimP(fimP), .fimT(fimT),
        .zeraE(zeraE), .contaE(contaE), .zeraRod(zeraRod), .contaRod(contaRod),
        .zeraT(zeraT), .contaT(contaT), .zeraP(zeraP), .contaP(contaP),
        .zeraR(zeraR), .registraR(registraR), .we(we), .sinal_led(sinal_led),
        .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
        .db_estado(db_estado)
    );

    assign outs = {zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraP, contaP,
                   zeraR, registraR, we, sinal_led, pronto, acertou, errou, timeout};

    // Clock generation.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; iniciar = 1'b1;
        step(); step();
        n_checks++;
        if ({db_estado, outs} !== {4'h0, 16'h0000}) begin
            n_errors++;
            $display("FAIL reset_hold: got state=%h outs=%h want state=0 outs=0000", db_estado, outs);
        end
        reset = 1'b0; iniciar = 1'b0;
        step();
        n_checks++;
        if ({db_estado, outs} !== {4'h0, 16'h0000}) begin
            n_errors++;
            $display("FAIL idle_stay: got state=%h outs=%h want state=0 outs=0000", db_estado, outs);
        end
    endtask

    task automatic test_start();
        iniciar = 1'b1; step(); iniciar = 1'b0;
        n_checks++;
        if ({db_estado, outs} !== {4'h1, 16'hAA80}) begin
            n_errors++;
            $display("FAIL preparacao: got state=%h outs=%h want state=1 outs=aa80", db_estado, outs);
        end
        step(); step();
        n_checks++;
        if ({db_estado, outs} !== {4'h2, 16'h0110}) begin
            n_errors++;
            $display("FAIL mostra_hold: got state=%h outs=%h want state=2 outs=0110", db_estado, outs);
        end
        fimP = 1'b1; #1;
        n_checks++;
        if ({db_estado, outs} !== {4'h2, 16'h0910}) begin
            n_errors++;
            $display("FAIL mostra_fimP: got state=%h outs=%h want state=2 outs=0910", db_estado, outs);
        end
        step(); fimP = 1'b0;
        n_checks++;
        if ({db_estado, outs} !== {4'h3, 16'h0400}) begin
            n_errors++;
            $display("FAIL espera_jogada: got state=%h outs=%h want state=3 outs=0400", db_estado, outs);
        end
    endtask

    task automatic test_round_advance();
        logic [3:0]  exp_s[8] = '{4'h4, 4'h5, 4'h7, 4'h8, 4'h8, 4'h9, 4'hA, 4'hB};
        logic [15:0] exp_o[8] = '{16'h0840, 16'h0000, 16'h4800, 16'h0400,
                                  16'h0400, 16'h0040, 16'h0020, 16'h9800};
        igual = 1'b1; enderecoIgualRodada = 1'b1; fimRod = 1'b0;
        for (int i = 0; i < 8; i++) begin
            jogada_feita = (i == 0 || i == 5) ? 1'b1 : 1'b0;
            step();
            jogada_feita = 1'b0;
            n_checks++;
            if ({db_estado, outs} !== {exp_s[i], exp_o[i]}) begin
                n_errors++;
                $display("FAIL round_advance[%0d]: got state=%h outs=%h want state=%h outs=%h",
                         i, db_estado, outs, exp_s[i], exp_o[i]);
            end
        end
        step();
        n_checks++;
        if ({db_estado, outs} !== {4'h3, 16'h0400}) begin
            n_errors++;
            $display("FAIL round_return: got state=%h outs=%h want state=3 outs=0400", db_estado, outs);
        end
    endtask

    task automatic test_next_address();
        logic [3:0]  exp_s[4] = '{4'h4, 4'h5, 4'h6, 4'h3};
        logic [15:0] exp_o[4] = '{16'h0840, 16'h0000, 16'h4000, 16'h0400};
        igual = 1'b1; enderecoIgualRodada = 1'b0; fimRod = 1'b0;
        for (int i = 0; i < 4; i++) begin
            jogada_feita = (i == 0) ? 1'b1 : 1'b0;
            step();
            jogada_feita = 1'b0;
            n_checks++;
            if ({db_estado, outs} !== {exp_s[i], exp_o[i]}) begin
                n_errors++;
                $display("FAIL next_address[%0d]: got state=%h outs=%h want state=%h outs=%h",
                         i, db_estado, outs, exp_s[i], exp_o[i]);
            end
        end
    endtask

    // Restart from a terminal state and walk back to espera_jogada.
    task automatic restart_to_play(input string tag);
        iniciar = 1'b1; step(); iniciar = 1'b0;
        n_checks++;
        if (db_estado !== 4'h1) begin
            n_errors++;
            $display("FAIL %s_restart: got state=%h want state=1", tag, db_estado);
        end
        step(); fimP = 1'b1; step(); fimP = 1'b0;
        n_checks++;
        if (db_estado !== 4'h3) begin
            n_errors++;
            $display("FAIL %s_replay: got state=%h want state=3", tag, db_estado);
        end
    endtask

    task automatic test_error();
        igual = 1'b0; enderecoIgualRodada = 1'b1; fimRod = 1'b0;
        jogada_feita = 1'b1; step(); jogada_feita = 1'b0;
        step(); step();
        n_checks++;
        if ({db_estado, outs} !== {4'hD, 16'h000A}) begin
            n_errors++;
            $display("FAIL errou: got state=%h outs=%h want state=d outs=000a", db_estado, outs);
        end
        step(); step();
        n_checks++;
        if ({db_estado, outs} !== {4'hD, 16'h000A}) begin
            n_errors++;
            $display("FAIL errou_hold: got state=%h outs=%h want state=d outs=000a", db_estado, outs);
        end
        restart_to_play("errou");
    endtask

    task automatic test_timeout();
        fimT = 1'b1; step(); fimT = 1'b0;
        n_checks++;
        if ({db_estado, outs} !== {4'hE, 16'h0009}) begin
            n_errors++;
            $display("FAIL timeout: got state=%h outs=%h want state=e outs=0009", db_estado, outs);
        end
        step();
        n_checks++;
        if (db_estado !== 4'hE) begin
            n_errors++;
            $display("FAIL timeout_hold: got state=%h want state=e", db_estado);
        end
        restart_to_play("timeout");
    endtask

    task automatic test_priority_and_win();
        jogada_feita = 1'b1; fimT = 1'b1; step(); jogada_feita = 1'b0; fimT = 1'b0;
        n_checks++;
        if (db_estado !== 4'h4) begin
            n_errors++;
            $display("FAIL priority_espera: got state=%h want state=4", db_estado);
        end
        igual = 1'b1; enderecoIgualRodada = 1'b1; fimRod = 1'b1;
        step(); step();
        n_checks++;
        if ({db_estado, outs} !== {4'hC, 16'h000C}) begin
            n_errors++;
            $display("FAIL acertou: got state=%h outs=%h want state=c outs=000c", db_estado, outs);
        end
        fimRod = 1'b0;
        restart_to_play("acertou");
    endtask

    task automatic test_reset_in_escreve();
        igual = 1'b1; enderecoIgualRodada = 1'b1; fimRod = 1'b0;
        jogada_feita = 1'b1; step(); jogada_feita = 1'b0;
        step(); step(); step();
        jogada_feita = 1'b1; fimT = 1'b1; step(); jogada_feita = 1'b0; fimT = 1'b0;
        n_checks++;
        if (db_estado !== 4'h9) begin
            n_errors++;
            $display("FAIL priority_nova: got state=%h want state=9", db_estado);
        end
        step();
        n_checks++;
        if ({db_estado, we} !== {4'hA, 1'b1}) begin
            n_errors++;
            $display("FAIL escreve: got state=%h we=%b want state=a we=1", db_estado, we);
        end
        reset = 1'b1; step();
        n_checks++;
        if ({db_estado, outs} !== {4'h0, 16'h0000}) begin
            n_errors++;
            $display("FAIL reset_escreve: got state=%h outs=%h want state=0 outs=0000", db_estado, outs);
        end
        reset = 1'b0; step();
        n_checks++;
        if ({db_estado, we} !== {4'h0, 1'b0}) begin
            n_errors++;
            $display("FAIL after_reset: got state=%h we=%b want state=0 we=0", db_estado, we);
        end
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; jogada_feita = 1'b0; igual = 1'b0;
        enderecoIgualRodada = 1'b0; fimRod = 1'b0; fimP = 1'b0; fimT = 1'b0;
        test_reset();
        test_start();
        test_round_advance();
        test_next_address();
        test_error();
        test_timeout();
        test_priority_and_win();
        test_reset_in_escreve();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
